// File: rtl/arb_pkg.sv
// Shared definitions for the two-requester round-robin arbiter.
//   state_t          : FSM state encoding (IDLE / G0 / G1)
//   DEFAULT_MAX_HOLD : default bound on consecutive grant cycles under contention
package arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        G0   = 2'b01,
        G1   = 2'b10
    } state_t;

    localparam int DEFAULT_MAX_HOLD = 4;

endpackage

// File: rtl/hold_counter.sv
// Saturating hold counter for the arbiter.
// Ports:
//   clk, rst_n : clock and synchronous active-low reset
//   clr        : clear to zero (takes priority over en)
//   en         : advance by one, saturating at MAX_HOLD-1
//   cnt        : current count
//   tc         : terminal count, high when cnt == MAX_HOLD-1
module hold_counter #(
    parameter int MAX_HOLD = 4,
    parameter int HW       = $clog2(MAX_HOLD + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [HW-1:0] cnt,
    output logic          tc
);

    assign tc = (cnt == HW'(MAX_HOLD - 1));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !tc) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mux2.sv
// Shared 2:1 datapath mux steered by the arbiter.
// Ports:
//   sel    : 0 routes d0, 1 routes d1
//   d0, d1 : master data inputs
//   y      : selected data
module mux2 #(
    parameter int W = 8
) (
    input  logic         sel,
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/rr_arbiter_2_1.sv
// Two-requester round-robin arbiter owning a shared 2:1 mux.
// Grants are registered and one-hot (or both low); a hold counter bounds how
// long one master keeps the resource while the other is waiting.
// Ports:
//   clk, rst_n   : clock and synchronous active-low reset
//   req0, req1   : requests from master 0 / master 1
//   gnt0, gnt1   : registered grants
//   sel          : select of the shared mux (0 = master 0, 1 = master 1)
//   busy         : either grant high
//   din0, din1   : master data into the shared mux
//   dout         : shared mux output
module rr_arbiter_2_1
    import arb_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int DATA_W   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              busy,
    input  logic [DATA_W-1:0] din0,
    input  logic [DATA_W-1:0] din1,
    output logic [DATA_W-1:0] dout
);

    localparam int HW = $clog2(MAX_HOLD + 1);

    state_t          state;
    state_t          nxt;
    logic            last;
    logic            hold_clr;
    logic            hold_en;
    logic            hold_tc;
    logic [HW-1:0]   hcnt;

    // Next-state decision. Under contention in IDLE the master that was not
    // granted most recently wins; an active grant is only preempted once the
    // hold counter has reached its terminal count.
    always_comb begin
        nxt = state;
        case (state)
            IDLE: begin
                if (req0 && req1)  nxt = last ? G0 : G1;
                else if (req0)     nxt = G0;
                else if (req1)     nxt = G1;
                else               nxt = IDLE;
            end
            G0: begin
                if (!req0)                nxt = req1 ? G1 : IDLE;
                else if (req1 && hold_tc) nxt = G1;
                else                      nxt = G0;
            end
            G1: begin
                if (!req1)                nxt = req0 ? G0 : IDLE;
                else if (req0 && hold_tc) nxt = G0;
                else                      nxt = G1;
            end
            default: nxt = IDLE;
        endcase
    end

    // Any state change (including falling back to IDLE) restarts the count;
    // holding a grant advances it even when the other master is quiet.
    assign hold_clr = (nxt != state);
    assign hold_en  = (nxt == state) && (state != IDLE);

    hold_counter #(
        .MAX_HOLD (MAX_HOLD),
        .HW       (HW)
    ) u_hold (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (hold_clr),
        .en    (hold_en),
        .cnt   (hcnt),
        .tc    (hold_tc)
    );

    // State, priority pointer and registered outputs. sel is only written on
    // entry to a grant state so it holds across IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            sel   <= 1'b0;
        end else begin
            state <= nxt;
            gnt0  <= (nxt == G0);
            gnt1  <= (nxt == G1);
            if (nxt == G0) begin
                last <= 1'b0;
                sel  <= 1'b0;
            end else if (nxt == G1) begin
                last <= 1'b1;
                sel  <= 1'b1;
            end
        end
    end

    assign busy = gnt0 | gnt1;

    mux2 #(
        .W (DATA_W)
    ) u_mux (
        .sel (sel),
        .d0  (din0),
        .d1  (din1),
        .y   (dout)
    );

endmodule

// File: tb/tb_rr_arbiter_2_1.sv
module tb_rr_arbiter_2_1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0, req1;
    logic [7:0] din0, din1;

    logic       gnt0, gnt1, sel, busy;
    logic [7:0] dout;
    logic       gnt0_1, gnt1_1, sel_1, busy_1;
    logic [7:0] dout_1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rr_arbiter_2_1 #(.MAX_HOLD(4), .DATA_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .gnt0(gnt0), .gnt1(gnt1), .sel(sel), .busy(busy),
        .din0(din0), .din1(din1), .dout(dout)
    );

    rr_arbiter_2_1 #(.MAX_HOLD(1), .DATA_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .req0(req0), .req1(req1),
        .gnt0(gnt0_1), .gnt1(gnt1_1), .sel(sel_1), .busy(busy_1),
        .din0(din0), .din1(din1), .dout(dout_1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // gnt0, gnt1, sel, busy of the MAX_HOLD=4 instance
    task automatic check_out(input string tag, input logic g0, input logic g1, input logic s, input logic b);
        check({tag, ".gnt0"}, {7'd0, gnt0}, {7'd0, g0});
        check({tag, ".gnt1"}, {7'd0, gnt1}, {7'd0, g1});
        check({tag, ".sel"},  {7'd0, sel},  {7'd0, s});
        check({tag, ".busy"}, {7'd0, busy}, {7'd0, b});
    endtask

    initial begin
        rst_n = 1'b0; req0 = 1'b1; req1 = 1'b1;
        din0 = 8'hA5; din1 = 8'h3C;

        // Reset held two cycles with both requests high
        tick(); tick();
        check_out("reset", 1'b0, 1'b0, 1'b0, 1'b0);
        check("reset.dout", dout, 8'hA5);

        // Release: last=1 so master 0 wins the tie
        rst_n = 1'b1;
        tick();
        check_out("first_tie", 1'b1, 1'b0, 1'b0, 1'b1);

        req0 = 1'b0; req1 = 1'b0;
        tick();
        check_out("to_idle", 1'b0, 1'b0, 1'b0, 1'b0);

        // Single requester for 10 cycles: never preempted
        req1 = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check_out($sformatf("single[%0d]", i), 1'b0, 1'b1, 1'b1, 1'b1);
        end
        check("single.dout", dout, 8'h3C);
        req1 = 1'b0;
        tick();
        check_out("single_drop", 1'b0, 1'b0, 1'b1, 1'b0);
        check("idle_hold.dout", dout, 8'h3C);

        // Contention from IDLE with last=1: G0 x4, G1 x4, G0 x4
        req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 12; i++) begin
            logic e0;
            e0 = ((i / 4) % 2) == 0;
            tick();
            check_out($sformatf("contend[%0d]", i), e0, ~e0, ~e0, 1'b1);
        end

        // Back-to-back handoff G0 -> G1 with no IDLE bubble
        req0 = 1'b0; req1 = 1'b1;
        tick();
        check_out("handoff01", 1'b0, 1'b1, 1'b1, 1'b1);
        // and G1 -> G0
        req0 = 1'b1; req1 = 1'b0;
        tick();
        check_out("handoff10", 1'b1, 1'b0, 1'b0, 1'b1);

        // Counter saturates while alone; late rival preempts on the next edge
        for (int i = 0; i < 6; i++) begin
            tick();
            check_out($sformatf("alone0[%0d]", i), 1'b1, 1'b0, 1'b0, 1'b1);
        end
        req1 = 1'b1;
        tick();
        check_out("sat_preempt", 1'b0, 1'b1, 1'b1, 1'b1);

        req0 = 1'b0; req1 = 1'b0;
        tick();
        check_out("idle_sel_hold", 1'b0, 1'b0, 1'b1, 1'b0);

        // Reset mid-grant: G1 with hcnt = 2
        req1 = 1'b1;
        tick(); tick(); tick();
        check_out("g1_hcnt2", 1'b0, 1'b1, 1'b1, 1'b1);
        rst_n = 1'b0; req0 = 1'b1;
        tick();
        check_out("mid_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;
        // Master 0 first after reset, full 4-cycle hold (hcnt was cleared)
        for (int i = 0; i < 5; i++) begin
            logic e0;
            e0 = (i < 4);
            tick();
            check_out($sformatf("post_reset[%0d]", i), e0, ~e0, ~e0, 1'b1);
        end

        // MAX_HOLD = 1 instance: alternate every cycle under contention
        rst_n = 1'b0;
        tick();
        check("mh1_reset.gnt0", {7'd0, gnt0_1}, 8'd0);
        check("mh1_reset.sel",  {7'd0, sel_1},  8'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            logic e0;
            e0 = (i % 2) == 0;
            tick();
            check($sformatf("mh1[%0d].gnt0", i), {7'd0, gnt0_1}, {7'd0, e0});
            check($sformatf("mh1[%0d].gnt1", i), {7'd0, gnt1_1}, {7'd0, ~e0});
            check($sformatf("mh1[%0d].sel", i),  {7'd0, sel_1},  {7'd0, ~e0});
            check($sformatf("mh1[%0d].dout", i), dout_1, e0 ? 8'hA5 : 8'h3C);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
